// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes.
// Latency: NOP 2, ADD/SUB 4, SW 3+n, LW 4+n cycles per instruction (n = MEM cycles, n >= 1).
// Backpressure: MEM stalls with its strobe held until mem_ready is sampled high; nothing else stalls.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   start             level request to leave IDLE; looked at only in IDLE
//   op_code, func     instruction fields from the IR; must be stable through the DECODE edge
//   mem_ready         data-memory acknowledge; looked at only in MEM
//   pc_we, ir_we      PC / IR write enables (FETCH only)
//   alu_sub           ALU subtract select (EXEC of SUB)
//   rf_we, wb_sel     register-file write enable and write-back source (WB only)
//   dm_re, dm_we      data-memory read / write strobes (MEM only)
//   busy              high outside IDLE and HALT
//   illegal           sticky: an unsupported instruction reached DECODE
//   instr_count       retired-instruction counter, wraps at 2^16
module mc_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  op_code,
    input  logic [5:0]  func,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ir_we,
    output logic        alu_sub,
    output logic        rf_we,
    output logic        dm_re,
    output logic        dm_we,
    output logic        wb_sel,
    output logic        busy,
    output logic        illegal,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_NOP = 3'd0,
        C_ADD = 3'd1,
        C_SUB = 3'd2,
        C_LW  = 3'd3,
        C_SW  = 3'd4,
        C_ILL = 3'd5
    } cls_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_NOP   = 6'b000000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;

    state_t      state_q;
    state_t      state_d;
    cls_t        cls_q;
    cls_t        cls_d;
    cls_t        dec_cls;
    logic        retire;
    logic        ill_set;
    logic [15:0] count_q;

    // Instruction classification from the live IR fields. Only consumed in
    // DECODE; afterwards the latched class alone steers the FSM and outputs,
    // so later changes on op_code/func cannot disturb the instruction.
    always_comb begin
        dec_cls = C_ILL;
        if (op_code == OP_RTYPE) begin
            case (func)
                FN_NOP:  dec_cls = C_NOP;
                FN_ADD:  dec_cls = C_ADD;
                FN_SUB:  dec_cls = C_SUB;
                default: dec_cls = C_ILL;
            endcase
        end else if (op_code == OP_LW) begin
            dec_cls = C_LW;
        end else if (op_code == OP_SW) begin
            dec_cls = C_SW;
        end
    end

    // Next-state, retire and Moore output decode.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        retire  = 1'b0;
        ill_set = 1'b0;
        pc_we   = 1'b0;
        ir_we   = 1'b0;
        alu_sub = 1'b0;
        rf_we   = 1'b0;
        dm_re   = 1'b0;
        dm_we   = 1'b0;
        wb_sel  = 1'b0;
        busy    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                pc_we   = 1'b1;
                ir_we   = 1'b1;
                busy    = 1'b1;
                state_d = S_DECODE;
            end

            S_DECODE: begin
                busy  = 1'b1;
                cls_d = dec_cls;
                case (dec_cls)
                    C_NOP: begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    C_ILL: begin
                        ill_set = 1'b1;
                        state_d = S_HALT;
                    end
                    default: state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                busy    = 1'b1;
                // Loads and stores use the adder for address generation.
                alu_sub = (cls_q == C_SUB);
                if (cls_q == C_LW || cls_q == C_SW) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                busy  = 1'b1;
                dm_re = (cls_q == C_LW);
                dm_we = (cls_q == C_SW);
                if (mem_ready) begin
                    if (cls_q == C_LW) begin
                        state_d = S_WB;
                    end else begin
                        // Stores have nothing to write back.
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end

            S_WB: begin
                busy    = 1'b1;
                rf_we   = 1'b1;
                wb_sel  = (cls_q == C_LW);
                retire  = 1'b1;
                state_d = S_FETCH;
            end

            S_HALT: begin
                // Only reset leaves HALT.
                state_d = S_HALT;
            end

            default: begin
                // Encoding 3'd7 is never entered legitimately; recover to IDLE.
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cls_q   <= C_NOP;
            illegal <= 1'b0;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            if (ill_set) begin
                illegal <= 1'b1;
            end
            if (retire) begin
                count_q <= count_q + 16'h0001;
            end
        end
    end

    assign instr_count = count_q;

endmodule
